// File: rtl/vga_tft_deframer.sv
// Recovers pixel position from a VGA sync stream and re-emits it as a DE-mode TFT stream.
// A lock FSM checks every sync edge against the programmed mode and flags deviations.
module vga_tft_deframer #(
  parameter int unsigned FW = 13,
  parameter int unsigned LW = 11
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [FW-1:0] i_hm_width,
  input  logic [FW-1:0] i_hm_porch,
  input  logic [FW-1:0] i_hm_synch,
  input  logic [FW-1:0] i_hm_raw,
  input  logic [LW-1:0] i_vm_height,
  input  logic [LW-1:0] i_vm_porch,
  input  logic [LW-1:0] i_vm_synch,
  input  logic [LW-1:0] i_vm_raw,
  input  logic          i_hsync,
  input  logic          i_vsync,
  input  logic [7:0]    i_red,
  input  logic [7:0]    i_grn,
  input  logic [7:0]    i_blu,
  output logic          o_de,
  output logic [FW-1:0] o_x,
  output logic [LW-1:0] o_y,
  output logic [7:0]    o_red,
  output logic [7:0]    o_grn,
  output logic [7:0]    o_blu,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_frame_start,
  output logic          o_locked,
  output logic          o_err
);

  typedef enum logic [1:0] {StIdle, StHchk, StHok, StLocked} state_e;

  state_e        state_q, state_d;
  logic          hs_prev_q, vs_prev_q;
  logic [FW-1:0] col_q, col_d, col_pred;
  logic [LW-1:0] line_q, line_d, line_pred, line_nov;
  logic          hfall, vfall, h_ok, v_ok, locked;
  logic          de_q, de_d, fs_q, fs_d, locked_q, err_q, err_d;
  logic [7:0]    red_q, red_d, grn_q, grn_d, blu_q, blu_d;

  // Sync-pulse end columns/lines are not needed to recover position.
  logic unused_synch;
  assign unused_synch = ^{i_hm_synch, i_vm_synch};

  always_comb begin
    hfall    = ~i_hsync & hs_prev_q;
    vfall    = ~i_vsync & vs_prev_q;
    col_pred = (col_q == i_hm_raw - 1'b1) ? '0 : col_q + 1'b1;
    col_d    = hfall ? i_hm_porch : col_pred;
    line_pred = (line_q == i_vm_raw - 1'b1) ? '0 : line_q + 1'b1;
    // Line the counter would hold if no vsync edge were seen this sample.
    line_nov = (col_d == '0 && !hfall) ? line_pred : line_q;
    line_d   = vfall ? i_vm_porch : line_nov;
    h_ok     = (col_pred == i_hm_porch);
    v_ok     = (line_nov == i_vm_porch);
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hfall) state_d = StHchk;
      end
      StHchk: begin
        if (hfall && h_ok) state_d = StHok;
      end
      StHok: begin
        if (hfall && !h_ok) state_d = StHchk;
        else if (vfall)     state_d = StLocked;
      end
      StLocked: begin
        if ((hfall && !h_ok) || (vfall && !v_ok)) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The sample that enters LOCKED and the sample that breaks it are both output unlocked.
  always_comb begin
    locked = (state_q == StLocked) && (state_d == StLocked);
    de_d   = locked && (col_d < i_hm_width) && (line_d < i_vm_height);
    fs_d   = de_d && (col_d == '0) && (line_d == '0);
    red_d  = de_d ? i_red : 8'h00;
    grn_d  = de_d ? i_grn : 8'h00;
    blu_d  = de_d ? i_blu : 8'h00;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= StIdle;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      col_q     <= '0;
      line_q    <= '0;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      red_q     <= 8'h00;
      grn_q     <= 8'h00;
      blu_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      hs_prev_q <= i_hsync;
      vs_prev_q <= i_vsync;
      col_q     <= col_d;
      line_q    <= line_d;
      de_q      <= de_d;
      fs_q      <= fs_d;
      locked_q  <= locked;
      err_q     <= err_d;
      red_q     <= red_d;
      grn_q     <= grn_d;
      blu_q     <= blu_d;
    end
  end

  // Previous-sync registers double as the one-cycle delayed sync outputs.
  assign o_de          = de_q;
  assign o_x           = col_q;
  assign o_y           = line_q;
  assign o_red         = red_q;
  assign o_grn         = grn_q;
  assign o_blu         = blu_q;
  assign o_hsync       = hs_prev_q;
  assign o_vsync       = vs_prev_q;
  assign o_frame_start = fs_q;
  assign o_locked      = locked_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_vga_tft_deframer.sv
// Directed bench for vga_tft_deframer using a small 16x8 raw mode (8x4 active).
module tb_vga_tft_deframer;
  localparam int unsigned FW = 13;
  localparam int unsigned LW = 11;
  localparam int HRAW = 16;
  localparam int VRAW = 8;
  localparam int FRAME = HRAW * VRAW;
  localparam int LOCK_S = 97;  // first sample after the lock-entering vfall at (0,6)

  logic          clk = 1'b0;
  logic          i_reset, i_hsync, i_vsync;
  logic [7:0]    i_red, i_grn, i_blu;
  logic          o_de, o_hsync, o_vsync, o_frame_start, o_locked, o_err;
  logic [FW-1:0] o_x;
  logic [LW-1:0] o_y;
  logic [7:0]    o_red, o_grn, o_blu;

  int total = 0;
  int bad = 0;
  int gc, gl, p_gc, p_gl;
  logic p_hs, p_vs;
  int de0, er0, de1, er1, de2, er2, de3, er3, de4, er4, de5, er5;

  vga_tft_deframer #(.FW(FW), .LW(LW)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_hm_width   (13'd8),
    .i_hm_porch   (13'd10),
    .i_hm_synch   (13'd12),
    .i_hm_raw     (13'd16),
    .i_vm_height  (11'd4),
    .i_vm_porch   (11'd6),
    .i_vm_synch   (11'd7),
    .i_vm_raw     (11'd8),
    .i_hsync      (i_hsync),
    .i_vsync      (i_vsync),
    .i_red        (i_red),
    .i_grn        (i_grn),
    .i_blu        (i_blu),
    .o_de         (o_de),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_red        (o_red),
    .o_grn        (o_grn),
    .o_blu        (o_blu),
    .o_hsync      (o_hsync),
    .o_vsync      (o_vsync),
    .o_frame_start(o_frame_start),
    .o_locked     (o_locked),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset();
    check_eq("rst_de", 32'(o_de), 32'd0);
    check_eq("rst_x", 32'(o_x), 32'd0);
    check_eq("rst_y", 32'(o_y), 32'd0);
    check_eq("rst_rgb", {8'h00, o_red, o_grn, o_blu}, 32'd0);
    check_eq("rst_hs", 32'(o_hsync), 32'd1);
    check_eq("rst_vs", 32'(o_vsync), 32'd1);
    check_eq("rst_fs", 32'(o_frame_start), 32'd0);
    check_eq("rst_lock", 32'(o_locked), 32'd0);
    check_eq("rst_err", 32'(o_err), 32'd0);
  endtask

  // Drive one sample from the reference generator, clock it, then step the generator.
  task automatic tick(input bit glitch_h, input bit extra_v, input bit rst);
    logic hs, vs;
    hs = !(gc >= 10 && gc < 12) && !glitch_h;
    vs = (gl != 6) && !extra_v;
    i_hsync = hs;
    i_vsync = vs;
    i_red = 8'(gc);
    i_grn = 8'(gl);
    i_blu = 8'hA5;
    i_reset = rst;
    p_gc = gc;
    p_gl = gl;
    p_hs = hs;
    p_vs = vs;
    @(posedge clk);
    #1;
    gc++;
    if (gc == HRAW) begin
      gc = 0;
      gl = (gl == VRAW - 1) ? 0 : gl + 1;
    end
  endtask

  task automatic expect_pix(input bit lk, input bit err);
    bit de;
    de = lk && p_gc < 8 && p_gl < 4;
    check_eq("locked", 32'(o_locked), 32'(lk));
    check_eq("err", 32'(o_err), 32'(err));
    check_eq("de", 32'(o_de), 32'(de));
    check_eq("fs", 32'(o_frame_start), 32'(de && p_gc == 0 && p_gl == 0));
    check_eq("hsync", 32'(o_hsync), 32'(p_hs));
    check_eq("vsync", 32'(o_vsync), 32'(p_vs));
    check_eq("rgb", {8'h00, o_red, o_grn, o_blu},
             de ? ((p_gc & 32'hFF) << 16 | (p_gl & 32'hFF) << 8 | 32'hA5) : 32'd0);
    if (lk) begin
      check_eq("x", 32'(o_x), 32'(p_gc));
      check_eq("y", 32'(o_y), 32'(p_gl));
    end
  endtask

  // Samples before drop_s and from LOCK_S onward are expected locked.
  task automatic run_frame(input int drop_s, input int glitch_s, input int rst_s,
                           input bit vmis, input bit err_drop,
                           output int de_cnt, output int err_cnt);
    bit lk;
    de_cnt = 0;
    err_cnt = 0;
    for (int s = 0; s < FRAME; s++) begin
      tick(s == glitch_s, vmis && gl == 2, s == rst_s);
      if (s == rst_s) begin
        check_reset();
      end else begin
        lk = (s < drop_s) || (s >= LOCK_S);
        expect_pix(lk, err_drop && s == drop_s);
      end
      de_cnt += int'(o_de);
      err_cnt += int'(o_err);
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_hsync = 1'b1;
    i_vsync = 1'b1;
    i_red = 8'hFF;
    i_grn = 8'hFF;
    i_blu = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      i_hsync = (i % 2) == 1;
      i_vsync = (i % 2) == 0;
      @(posedge clk);
      #1;
      check_reset();
    end
    gc = 0;
    gl = 0;
    run_frame(0, -1, -1, 1'b0, 1'b0, de0, er0);     // acquisition
    run_frame(FRAME, -1, -1, 1'b0, 1'b0, de1, er1); // steady locked frame
    run_frame(19, 19, -1, 1'b0, 1'b1, de2, er2);    // extra hsync fall at (3,1)
    run_frame(32, -1, -1, 1'b1, 1'b1, de3, er3);    // vsync on line 2
    run_frame(36, -1, 36, 1'b0, 1'b0, de4, er4);    // reset at (4,2)
    run_frame(FRAME, -1, -1, 1'b0, 1'b0, de5, er5); // relocked frame
    check_eq("de_cnt_f0", 32'(de0), 32'd0);
    check_eq("de_cnt_f1", 32'(de1), 32'd32);
    check_eq("de_cnt_f2", 32'(de2), 32'd11);
    check_eq("de_cnt_f3", 32'(de3), 32'd16);
    check_eq("de_cnt_f4", 32'(de4), 32'd20);
    check_eq("de_cnt_f5", 32'(de5), 32'd32);
    check_eq("err_cnt_f0", 32'(er0), 32'd0);
    check_eq("err_cnt_f1", 32'(er1), 32'd0);
    check_eq("err_cnt_f2", 32'(er2), 32'd1);
    check_eq("err_cnt_f3", 32'(er3), 32'd1);
    check_eq("err_cnt_f4", 32'(er4), 32'd0);
    check_eq("err_cnt_f5", 32'(er5), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
